cv32e40p_obi_mem_arbiter: RTL and testbench
===========================================

Name: cv32e40p_obi_mem_arbiter

Overview:
- Shares one OBI-style memory port between the core's instruction-fetch and data (LSU) master interfaces.
- Sits between the cv32e40p top level and a single-ported memory or bus slave.
- Arbitrates requests and holds the winner stable until granted.
- Tracks outstanding transactions so every rvalid is routed back to the master that issued it.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
MAX_OUTSTANDING, 2, depth of the response-routing FIFO (>=1)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (data wins)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch request accepted
instr_addr_i  in  ADDR_WIDTH  fetch address
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_WIDTH  fetch read data
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU request accepted
data_addr_i  in  ADDR_WIDTH  LSU address
data_we_i  in  1  LSU write enable
data_be_i  in  DATA_WIDTH/8  LSU byte enables
data_wdata_i  in  DATA_WIDTH  LSU write data
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  DATA_WIDTH  LSU read data
mem_req_o  out  1  request to memory
mem_gnt_i  in  1  memory accepted request
mem_addr_o  out  ADDR_WIDTH  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  DATA_WIDTH  memory read data
err_o  out  1  sticky protocol error (rvalid with nothing outstanding)

Behaviour:
- Reset (rst_i sampled high at rising edge) clears all state:
  - routing FIFO empty
  - lock cleared
  - last_grant = INSTR, so data wins the first round-robin tie
  - err_o = 0
- All other outputs are combinational from state and inputs; none are registered.
- Handshake: a transfer occurs in a cycle where mem_req_o & mem_gnt_i.
  - Zero-cycle request latency: master req to mem_req_o is combinational.
  - Response latency is whatever the memory provides.
- Selection:
  - Lock set: winner = locked master.
  - ARB_MODE=1: data if data_req_i, else instr.
  - ARB_MODE=0: when both request, the master not equal to last_grant wins; when one requests, that one wins.
- mem_req_o = (instr_req_i | data_req_i) & ~fifo_full.
  - Full FIFO blocks new requests even if a pop occurs the same cycle.
- Mux to memory:
  - Winner data: addr/we/be/wdata pass through from the data port.
  - Winner instr: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
  - No winner: all address/control outputs are 0.
- gnt routing: winner_gnt_o = mem_req_o & mem_gnt_i; the loser's gnt_o = 0.
- Lock FSM, states UNLOCKED and LOCKED(owner):
  - UNLOCKED -> LOCKED(winner) when mem_req_o & ~mem_gnt_i.
  - LOCKED -> UNLOCKED on mem_gnt_i.
  - This keeps the un-granted address stable per OBI.
- last_grant updates to the winner on every transfer.
- Routing FIFO:
  - Push owner ID on transfer; pop on mem_rvalid_i.
  - Simultaneous push and pop allowed; count unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - mem_rvalid_i drives rvalid_o of the FIFO head owner only.
  - mem_rdata_i is broadcast to both rdata outputs.
- mem_rvalid_i with FIFO empty: no rvalid_o asserted, no pop, err_o set and held until reset.
- A master dropping req while locked is a master protocol violation. It is not checked; the lock holds until gnt.
- Reset mid-transaction discards outstanding entries. Later rvalids then raise err_o.

Decomposition:
- Package cv32e40p_obi_arb_pkg:
  - typedef enum owner_e {OWNER_INSTR, OWNER_DATA}
  - ARB_RR and ARB_FIXED constants
- Sub-module cv32e40p_obi_id_fifo: parameterised depth, 1-bit payload, full/empty flags, synchronous active-high reset.

Test Plan:
- Only instr_req_i=1 at addr 0x80, mem_gnt_i=1, rvalid 2 cycles later with rdata 0x00000013 -> instr_gnt_o=1 same cycle; mem_be_o=4'hF, mem_we_o=0; instr_rvalid_o=1 with 0x13; data_rvalid_o=0.
- ARB_MODE=0, both req held high, mem_gnt_i=1 every cycle -> grants alternate DATA, INSTR, DATA, INSTR from reset; FIFO full after 2 grants blocks mem_req_o until an rvalid arrives.
- Data write addr 0x1000, be=4'b0011, wdata 0xDEADBEEF, mem_gnt_i low for 3 cycles, instr_req_i rising in cycle 2 -> mem outputs stay on the data request all 4 cycles; instr_gnt_o=0 until the data grant.
- Interleaved pushes INSTR then DATA, rvalids return in order -> first rvalid routes to instr only, second to data only; same-cycle push+pop leaves count unchanged.
- mem_rvalid_i=1 with nothing outstanding -> no rvalid_o; err_o=1 and stays 1 until rst_i=1, then 0.
- rst_i asserted with 2 outstanding, then 2 rvalids -> FIFO empty after reset; err_o=1 after the first stray rvalid.

Source files
------------

// File: rtl/cv32e40p_obi_arb_pkg.sv
// Shared types and constants for the OBI instruction/data memory arbiter.
//   owner_e      : which master issued a request (also the routing-FIFO payload)
//   lock_state_e : state of the arbiter's request-hold FSM
//   ARB_RR       : round-robin arbitration
//   ARB_FIXED    : fixed priority, data master wins
package cv32e40p_obi_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/cv32e40p_obi_id_fifo.sv
// Small FIFO of 1-bit owner IDs, one entry per accepted-but-unanswered request.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data_i: write data_i at the tail
//   pop_i        : drop the head entry
//   data_o       : head entry
//   full_o/empty_o: occupancy flags
// The caller never pushes when full nor pops when empty.
module cv32e40p_obi_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic data_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] mem_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Shares one OBI memory port between the instruction-fetch and LSU masters.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   instr_*            : fetch master (read-only request, gnt, rvalid/rdata)
//   data_*             : LSU master (addr/we/be/wdata request, gnt, rvalid/rdata)
//   mem_*              : single OBI slave port
//   err_o              : sticky, set by an rvalid with nothing outstanding
// Handshake: a request transfers in any cycle with mem_req_o & mem_gnt_i. Once
// mem_req_o is raised without gnt the winner is locked and its address/control
// stay on mem_* until granted. Responses come back in order; each transfer
// pushes its owner into an ID FIFO whose head steers mem_rvalid_i.
module cv32e40p_obi_mem_arbiter
  import cv32e40p_obi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ARB_MODE        = ARB_RR
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  lock_state_e lock_state_q, lock_state_d;
  owner_e      lock_owner_q, lock_owner_d;
  owner_e      last_grant_q, last_grant_d;
  logic        err_q, err_d;

  owner_e winner;
  logic   winner_valid;
  logic   xfer;
  logic   fifo_full, fifo_empty, fifo_head, fifo_pop;

  // Winner selection. A lock overrides arbitration so an un-granted request
  // cannot be replaced by the other master.
  always_comb begin
    winner = OWNER_INSTR;
    if (lock_state_q == LOCK_LOCKED) begin
      winner = lock_owner_q;
    end else if (ARB_MODE == ARB_FIXED) begin
      winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
    end else if (instr_req_i && data_req_i) begin
      winner = (last_grant_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    end else begin
      winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
    end
  end

  assign winner_valid = (lock_state_q == LOCK_LOCKED) | instr_req_i | data_req_i;

  // A full FIFO blocks requests even when a pop happens this cycle; this keeps
  // the request path independent of mem_rvalid_i.
  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full;
  assign xfer      = mem_req_o & mem_gnt_i;

  assign instr_gnt_o = xfer & (winner == OWNER_INSTR);
  assign data_gnt_o  = xfer & (winner == OWNER_DATA);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (winner_valid) begin
      if (winner == OWNER_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = '1;
      end
    end
  end

  // Lock FSM and arbitration history.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    case (lock_state_q)
      LOCK_UNLOCKED: begin
        if (mem_req_o && !mem_gnt_i) begin
          lock_state_d = LOCK_LOCKED;
          lock_owner_d = winner;
        end
      end
      LOCK_LOCKED: begin
        if (mem_gnt_i) lock_state_d = LOCK_UNLOCKED;
      end
      default: lock_state_d = LOCK_UNLOCKED;
    endcase
    if (xfer) last_grant_d = winner;
  end

  // Response routing: only a non-empty FIFO may be popped; a stray rvalid
  // is recorded as an error instead.
  assign fifo_pop = mem_rvalid_i & ~fifo_empty;
  assign err_d    = err_q | (mem_rvalid_i & fifo_empty);

  assign instr_rvalid_o = fifo_pop & (owner_e'(fifo_head) == OWNER_INSTR);
  assign data_rvalid_o  = fifo_pop & (owner_e'(fifo_head) == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_o          = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_state_q <= LOCK_UNLOCKED;
      lock_owner_q <= OWNER_INSTR;
      last_grant_q <= OWNER_INSTR;
      err_q        <= 1'b0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  cv32e40p_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (xfer),
    .pop_i   (fifo_pop),
    .data_i  (logic'(winner)),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_cv32e40p_obi_mem_arbiter.sv
module tb_cv32e40p_obi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          instr_req, instr_gnt, instr_rvalid;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic          data_req, data_gnt, data_we, data_rvalid;
  logic [AW-1:0] data_addr;
  logic [BW-1:0] data_be;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_gnt, mem_we, mem_rvalid, err;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  cv32e40p_obi_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .ARB_MODE(0)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
    .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  // ---------------- records ----------------
  typedef struct {
    logic          mreq;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [BW-1:0] mbe;
    logic [DW-1:0] mwdata;
    logic          ig, dg, irv, drv;
    logic [DW-1:0] rdata;
    logic          err;
  } out_t;

  typedef struct {
    logic          rst;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic          dreq;
    logic [AW-1:0] daddr;
    logic          dwe;
    logic [BW-1:0] dbe;
    logic [DW-1:0] dwdata;
    logic          gnt;
    logic          rv;
    logic [DW-1:0] rdata;
    out_t          exp;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ireq, input logic [AW-1:0] iaddr,
    input logic dreq, input logic [AW-1:0] daddr, input logic dwe,
    input logic [BW-1:0] dbe, input logic [DW-1:0] dwd, input logic gnt,
    input logic rv, input logic [DW-1:0] rd,
    input logic e_mreq, input logic [AW-1:0] e_maddr, input logic e_mwe,
    input logic [BW-1:0] e_mbe, input logic [DW-1:0] e_mwd,
    input logic e_ig, input logic e_dg, input logic e_irv, input logic e_drv,
    input logic e_err);
    vec_t v;
    v.rst = r; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr;
    v.dwe = dwe; v.dbe = dbe; v.dwdata = dwd; v.gnt = gnt; v.rv = rv; v.rdata = rd;
    v.exp.mreq = e_mreq; v.exp.maddr = e_maddr; v.exp.mwe = e_mwe;
    v.exp.mbe = e_mbe; v.exp.mwdata = e_mwd; v.exp.ig = e_ig; v.exp.dg = e_dg;
    v.exp.irv = e_irv; v.exp.drv = e_drv; v.exp.rdata = rd; v.exp.err = e_err;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_outputs(input out_t e, input string tag);
    chk({tag, ".mem_req"},     64'(mem_req),     64'(e.mreq));
    chk({tag, ".mem_addr"},    64'(mem_addr),    64'(e.maddr));
    chk({tag, ".mem_we"},      64'(mem_we),      64'(e.mwe));
    chk({tag, ".mem_be"},      64'(mem_be),      64'(e.mbe));
    chk({tag, ".mem_wdata"},   64'(mem_wdata),   64'(e.mwdata));
    chk({tag, ".instr_gnt"},   64'(instr_gnt),   64'(e.ig));
    chk({tag, ".data_gnt"},    64'(data_gnt),    64'(e.dg));
    chk({tag, ".instr_rvalid"},64'(instr_rvalid),64'(e.irv));
    chk({tag, ".data_rvalid"}, 64'(data_rvalid), 64'(e.drv));
    chk({tag, ".instr_rdata"}, 64'(instr_rdata), 64'(e.rdata));
    chk({tag, ".data_rdata"},  64'(data_rdata),  64'(e.rdata));
    chk({tag, ".err"},         64'(err),         64'(e.err));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    rst = v.rst; instr_req = v.ireq; instr_addr = v.iaddr;
    data_req = v.dreq; data_addr = v.daddr; data_we = v.dwe; data_be = v.dbe;
    data_wdata = v.dwdata; mem_gnt = v.gnt; mem_rvalid = v.rv; mem_rdata = v.rdata;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_outputs(v.exp, tag);
  endtask

  // ---------------- reference model ----------------
  // Owners of outstanding requests in issue order (0 = instr, 1 = data).
  bit mq[$];
  bit m_last, m_lock, m_lock_own, m_err;

  task automatic model_reset();
    mq.delete(); m_last = 0; m_lock = 0; m_lock_own = 0; m_err = 0;
  endtask

  function automatic bit model_winner();
    if (m_lock) return m_lock_own;
    if (instr_req && data_req) return !m_last;
    return data_req;
  endfunction

  function automatic out_t model_out();
    out_t e;
    bit   w;
    bit   any;
    w   = model_winner();
    any = instr_req | data_req;
    e.mreq = any && (mq.size() < MO);
    e.maddr = '0; e.mwe = 0; e.mbe = '0; e.mwdata = '0;
    if (any || m_lock) begin
      if (w) begin
        e.maddr = data_addr; e.mwe = data_we; e.mbe = data_be; e.mwdata = data_wdata;
      end else begin
        e.maddr = instr_addr; e.mbe = '1;
      end
    end
    e.ig  = e.mreq && mem_gnt && !w;
    e.dg  = e.mreq && mem_gnt && w;
    e.irv = mem_rvalid && mq.size() > 0 && mq[0] == 0;
    e.drv = mem_rvalid && mq.size() > 0 && mq[0] == 1;
    e.rdata = mem_rdata;
    e.err = m_err;
    return e;
  endfunction

  task automatic model_update();
    bit w;
    bit req_ok;
    w      = model_winner();
    req_ok = (instr_req | data_req) && (mq.size() < MO);
    if (rst) begin
      model_reset();
    end else begin
      if (mem_rvalid) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1;
      end
      if (req_ok && mem_gnt) begin
        mq.push_back(w);
        m_last = w;
      end
      if (!m_lock && req_ok && !mem_gnt) begin
        m_lock = 1; m_lock_own = w;
      end else if (m_lock && mem_gnt) begin
        m_lock = 0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 0,0, 0,0,0,0,0, 0, 0,0, 0,0,0,0,0, 0,0,0,0, 0);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // rst, ireq,iaddr, dreq,daddr,we,be,wdata, gnt, rv,rdata | mreq,maddr,we,be,wdata, ig,dg,irv,drv, err
    tbl.push_back(idle);
    // single fetch, response two cycles later
    tbl.push_back(mk(0, 1,32'h80, 0,0,0,0,0, 1, 0,0,             1,32'h80,0,4'hF,0, 1,0,0,0, 0));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h13,             0,0,0,0,0, 0,0,1,0, 0));
    // both requesting: D, I, then FIFO full blocks, pop does not unblock same cycle
    tbl.push_back(mk(0, 1,32'h100, 1,32'h2000,0,4'hF,32'h55, 1, 0,0,            1,32'h2000,0,4'hF,32'h55, 0,1,0,0, 0));
    tbl.push_back(mk(0, 1,32'h100, 1,32'h2000,0,4'hF,32'h55, 1, 0,0,            1,32'h100,0,4'hF,0,       1,0,0,0, 0));
    tbl.push_back(mk(0, 1,32'h100, 1,32'h2000,0,4'hF,32'h55, 1, 0,0,            0,32'h2000,0,4'hF,32'h55, 0,0,0,0, 0));
    tbl.push_back(mk(0, 1,32'h100, 1,32'h2000,0,4'hF,32'h55, 1, 1,32'hAAAA5555, 0,32'h2000,0,4'hF,32'h55, 0,0,0,1, 0));
    tbl.push_back(mk(0, 1,32'h100, 1,32'h2000,0,4'hF,32'h55, 1, 0,0,            1,32'h2000,0,4'hF,32'h55, 0,1,0,0, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h11,             0,0,0,0,0, 0,0,1,0, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h22,             0,0,0,0,0, 0,0,0,1, 0));
    // data write stalled 3 cycles, instr arrives mid-stall and must wait
    tbl.push_back(mk(0, 0,0,       1,32'h1000,1,4'h3,32'hDEADBEEF, 0, 0,0, 1,32'h1000,1,4'h3,32'hDEADBEEF, 0,0,0,0, 0));
    tbl.push_back(mk(0, 0,0,       1,32'h1000,1,4'h3,32'hDEADBEEF, 0, 0,0, 1,32'h1000,1,4'h3,32'hDEADBEEF, 0,0,0,0, 0));
    tbl.push_back(mk(0, 1,32'h300, 1,32'h1000,1,4'h3,32'hDEADBEEF, 0, 0,0, 1,32'h1000,1,4'h3,32'hDEADBEEF, 0,0,0,0, 0));
    tbl.push_back(mk(0, 1,32'h300, 1,32'h1000,1,4'h3,32'hDEADBEEF, 1, 0,0, 1,32'h1000,1,4'h3,32'hDEADBEEF, 0,1,0,0, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h33,             0,0,0,0,0, 0,0,0,1, 0));
    // interleaved I then D, same-cycle push+pop keeps count at 1
    tbl.push_back(mk(0, 1,32'h300, 1,32'h2000,0,4'hF,32'h55, 1, 0,0,       1,32'h300,0,4'hF,0,       1,0,0,0, 0));
    tbl.push_back(mk(0, 0,0,       1,32'h2000,0,4'hF,32'h55, 1, 1,32'h44,  1,32'h2000,0,4'hF,32'h55, 0,1,1,0, 0));
    tbl.push_back(mk(0, 1,32'h300, 0,0,0,0,0,                1, 0,0,       1,32'h300,0,4'hF,0,       1,0,0,0, 0));
    tbl.push_back(mk(0, 1,32'h300, 0,0,0,0,0,                1, 0,0,       0,32'h300,0,4'hF,0,       0,0,0,0, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h55,             0,0,0,0,0, 0,0,0,1, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h66,             0,0,0,0,0, 0,0,1,0, 0));
    // stray rvalid: sticky error until reset
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h77,             0,0,0,0,0, 0,0,0,0, 0));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 0,0,                  0,0,0,0,0, 0,0,0,0, 1));
    tbl.push_back(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h88,             0,0,0,0,0, 0,0,0,0, 1));
    tbl.push_back(mk(1, 0,0, 0,0,0,0,0, 0, 0,0,                  0,0,0,0,0, 0,0,0,0, 1));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Reset with two requests outstanding, then two rvalids.
    step(mk(0, 1,32'h400, 1,32'h500,0,4'hF,0, 1, 0,0, 1,32'h500,0,4'hF,0, 0,1,0,0, 0), "rst_seq0");
    step(mk(0, 1,32'h400, 1,32'h500,0,4'hF,0, 1, 0,0, 1,32'h400,0,4'hF,0, 1,0,0,0, 0), "rst_seq1");
    step(mk(1, 0,0, 0,0,0,0,0, 0, 0,0,           0,0,0,0,0, 0,0,0,0, 0), "rst_seq2");
    step(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h99,      0,0,0,0,0, 0,0,0,0, 0), "rst_seq3");
    step(mk(0, 0,0, 0,0,0,0,0, 0, 1,32'h9A,      0,0,0,0,0, 0,0,0,0, 1), "rst_seq4");
    step(mk(0, 1,32'h400, 1,32'h500,0,4'hF,0, 1, 0,0, 1,32'h500,0,4'hF,0, 0,1,0,0, 1), "rst_seq5");

    // Randomized run against the reference model.
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      out_t e;
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if (!(m_lock && m_lock_own == 0)) begin
        instr_req  = $urandom_range(0, 1);
        instr_addr = $urandom;
      end
      if (!(m_lock && m_lock_own == 1)) begin
        data_req   = $urandom_range(0, 1);
        data_addr  = $urandom;
        data_we    = $urandom_range(0, 1);
        data_be    = BW'($urandom);
        data_wdata = $urandom;
      end
      if (m_lock) begin
        if (m_lock_own) data_req = 1'b1;
        else            instr_req = 1'b1;
      end
      mem_gnt    = ($urandom_range(0, 2) != 0);
      mem_rvalid = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      mem_rdata  = $urandom;
      #1;
      e = model_out();
      check_outputs(e, "rand");
      model_update();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
